// File: rtl/mult_div_ctrl_pkg.sv
// Shared types for the multiply/divide controller.
// State encoding, op codes and iteration count.
package mult_div_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MULT,
    ST_DIV,
    ST_FIX,
    ST_DONE
  } md_state_e;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  localparam int ITER = 32;
  localparam int CW   = $clog2(ITER);

endpackage

// File: rtl/mult_div_ctrl_addsub.sv
// md_addsub: add/subtract with carry-out, shared by Booth and restoring steps.
// Ports: i_a, i_b operands; i_sub selects a-b; o_sum result; o_cout carry.
module md_addsub #(
  parameter int W = 33
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_sub,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W-1:0] w_b;
  logic [W:0]   w_full;

  assign w_b    = i_sub ? ~i_b : i_b;
  assign w_full = {1'b0, i_a} + {1'b0, w_b} + {{W{1'b0}}, i_sub};
  assign o_sum  = w_full[W-1:0];
  assign o_cout = w_full[W];

endmodule

// File: rtl/mult_div_ctrl.sv
// Sequential signed MULT/DIV unit with HI/LO result registers.
// Ports: clock/reset, start/op/src_a/src_b in; busy/done/div_zero/hi_out/lo_out out.
module mult_div_ctrl
  import mult_div_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int W = WIDTH;

  md_state_e r_state;
  md_state_e w_next;

  logic [W-1:0]  r_hi;
  logic [W-1:0]  r_lo;
  logic [W-1:0]  r_acc_hi;
  logic [W-1:0]  r_acc_lo;
  logic [W-1:0]  r_m;
  logic          r_q1;
  logic          r_op;
  logic          r_neg_q;
  logic          r_neg_r;
  logic          r_dz;
  logic [CW-1:0] r_cnt;

  logic          w_last;
  logic          w_b_zero;
  logic [1:0]    w_booth;
  logic [W:0]    w_add_a;
  logic [W:0]    w_add_b;
  logic          w_sub;
  logic [W:0]    w_sum;
  logic          w_cout;
  logic [W-1:0]  w_abs_a;
  logic [W-1:0]  w_abs_b;

  assign w_last   = (r_cnt == CW'(ITER - 1));
  assign w_b_zero = (src_b == '0);
  assign w_booth  = {r_acc_lo[0], r_q1};
  assign w_abs_a  = src_a[W-1] ? -src_a : src_a;
  assign w_abs_b  = src_b[W-1] ? -src_b : src_b;

  always_ff @(posedge clock) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (start) begin
          if (op == OP_DIV && w_b_zero) w_next = ST_DONE;
          else if (op == OP_DIV)        w_next = ST_DIV;
          else                          w_next = ST_MULT;
        end
      end
      ST_MULT: if (w_last) w_next = ST_FIX;
      ST_DIV:  if (w_last) w_next = ST_FIX;
      ST_FIX:  w_next = ST_DONE;
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // Divide: shift the next dividend bit into the partial remainder
  // and trial-subtract the divisor; carry-out means it fits.
  // Booth: sign-extend to 33 bits so the add never overflows
  // before the arithmetic right shift.
  always_comb begin
    w_add_a = '0;
    w_add_b = '0;
    w_sub   = 1'b0;
    if (r_state == ST_DIV) begin
      w_add_a = {r_acc_hi, r_acc_lo[W-1]};
      w_add_b = {1'b0, r_m};
      w_sub   = 1'b1;
    end else begin
      w_add_a = {r_acc_hi[W-1], r_acc_hi};
      w_sub   = (w_booth == 2'b10);
      if (w_booth == 2'b01 || w_booth == 2'b10)
        w_add_b = {r_m[W-1], r_m};
    end
  end

  md_addsub #(
    .W(W + 1)
  ) u_addsub (
    .i_a   (w_add_a),
    .i_b   (w_add_b),
    .i_sub (w_sub),
    .o_sum (w_sum),
    .o_cout(w_cout)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_m      <= '0;
      r_q1     <= 1'b0;
      r_op     <= OP_MULT;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_dz     <= 1'b0;
      r_cnt    <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op     <= op;
            r_cnt    <= '0;
            r_acc_hi <= '0;
            r_q1     <= 1'b0;
            r_dz     <= (op == OP_DIV) && w_b_zero;
            if (op == OP_DIV) begin
              r_acc_lo <= w_abs_a;
              r_m      <= w_abs_b;
              r_neg_q  <= src_a[W-1] ^ src_b[W-1];
              r_neg_r  <= src_a[W-1];
            end else begin
              r_acc_lo <= src_b;
              r_m      <= src_a;
              r_neg_q  <= 1'b0;
              r_neg_r  <= 1'b0;
            end
          end
        end
        ST_MULT: begin
          r_acc_hi <= w_sum[W:1];
          r_acc_lo <= {w_sum[0], r_acc_lo[W-1:1]};
          r_q1     <= r_acc_lo[0];
          r_cnt    <= r_cnt + CW'(1);
        end
        ST_DIV: begin
          r_acc_hi <= w_cout ? w_sum[W-1:0] : w_add_a[W-1:0];
          r_acc_lo <= {r_acc_lo[W-2:0], w_cout};
          r_cnt    <= r_cnt + CW'(1);
        end
        ST_FIX: begin
          if (r_op == OP_DIV) begin
            r_lo <= r_neg_q ? -r_acc_lo : r_acc_lo;
            r_hi <= r_neg_r ? -r_acc_hi : r_acc_hi;
          end else begin
            r_lo <= r_acc_lo;
            r_hi <= r_acc_hi;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = (r_state == ST_DONE);
  assign div_zero = (r_state == ST_DONE) && r_dz;
  assign hi_out   = r_hi;
  assign lo_out   = r_lo;

endmodule

// File: tb/tb_mult_div_ctrl.sv
// Directed testbench for mult_div_ctrl.
// Feature tasks drive vectors and compare against hand-computed values.
module tb_mult_div_ctrl;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  int errors = 0;
  int checks = 0;

  mult_div_ctrl #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .op      (op),
    .src_a   (src_a),
    .src_b   (src_b),
    .busy    (busy),
    .done    (done),
    .div_zero(div_zero),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Starts one op in cycle 0 and watches 40 cycles. Operands are
  // scrambled after capture; an extra start may be injected.
  task automatic drive_op(
    input  logic        o,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  int          extra_start_at,
    output int          first_done,
    output int          ndone,
    output logic        dz_at_done,
    output logic        busy1
  );
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    first_done = -1;
    ndone      = 0;
    dz_at_done = 1'b0;
    busy1      = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == 1) begin
        start = 1'b0;
        busy1 = busy;
        src_a = $urandom;
        src_b = $urandom;
      end
      if (cyc == extra_start_at) begin
        start = 1'b1;
        op    = ~o;
      end
      if (cyc == extra_start_at + 1) start = 1'b0;
      if (done) begin
        ndone++;
        if (first_done < 0) begin
          first_done = cyc;
          dz_at_done = div_zero;
        end
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    start = 1'b0;
    op    = 1'b0;
    src_a = '0;
    src_b = '0;
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_zero} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got=%b want=000", {busy, done, div_zero});
    end
    checks++;
    if ({hi_out, lo_out} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo got=%h_%h want=0", hi_out, lo_out);
    end
    reset = 1'b0;
  endtask

  task automatic test_mult;
    logic [31:0] va [4];
    logic [31:0] vb [4];
    logic [31:0] eh [4];
    logic [31:0] el [4];
    int fd, nd;
    logic dz, b1;
    va[0] = 32'd7;        vb[0] = 32'hFFFFFFFD;
    eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFEB;
    va[1] = 32'h80000000; vb[1] = 32'h80000000;
    eh[1] = 32'h40000000; el[1] = 32'h00000000;
    va[2] = 32'h00010000; vb[2] = 32'h00010000;
    eh[2] = 32'h00000001; el[2] = 32'h00000000;
    va[3] = 32'hFFFFFFFF; vb[3] = 32'hFFFFFFFF;
    eh[3] = 32'h00000000; el[3] = 32'h00000001;
    for (int i = 0; i < 4; i++) begin
      drive_op(1'b0, va[i], vb[i], -10, fd, nd, dz, b1);
      checks++;
      if (b1 !== 1'b1) begin
        errors++;
        $display("FAIL mult%0d_busy got=%b want=1", i, b1);
      end
      checks++;
      if (fd != 34 || nd != 1) begin
        errors++;
        $display("FAIL mult%0d_done cyc=%0d n=%0d want cyc=34 n=1",
                 i, fd, nd);
      end
      checks++;
      if (dz !== 1'b0) begin
        errors++;
        $display("FAIL mult%0d_dz got=%b want=0", i, dz);
      end
      checks++;
      if (hi_out !== eh[i] || lo_out !== el[i]) begin
        errors++;
        $display("FAIL mult%0d_result got=%h_%h want=%h_%h",
                 i, hi_out, lo_out, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div;
    logic [31:0] va [5];
    logic [31:0] vb [5];
    logic [31:0] eh [5];
    logic [31:0] el [5];
    int fd, nd;
    logic dz, b1;
    va[0] = 32'hFFFFFFF9; vb[0] = 32'd2;
    eh[0] = 32'hFFFFFFFF; el[0] = 32'hFFFFFFFD;
    va[1] = 32'd100;      vb[1] = 32'd7;
    eh[1] = 32'd2;        el[1] = 32'd14;
    va[2] = 32'd7;        vb[2] = 32'hFFFFFFFE;
    eh[2] = 32'd1;        el[2] = 32'hFFFFFFFD;
    va[3] = 32'hFFFFFFF9; vb[3] = 32'hFFFFFFFE;
    eh[3] = 32'hFFFFFFFF; el[3] = 32'd3;
    va[4] = 32'd3;        vb[4] = 32'd10;
    eh[4] = 32'd3;        el[4] = 32'd0;
    for (int i = 0; i < 5; i++) begin
      drive_op(1'b1, va[i], vb[i], -10, fd, nd, dz, b1);
      checks++;
      if (fd != 34 || nd != 1) begin
        errors++;
        $display("FAIL div%0d_done cyc=%0d n=%0d want cyc=34 n=1",
                 i, fd, nd);
      end
      checks++;
      if (dz !== 1'b0) begin
        errors++;
        $display("FAIL div%0d_dz got=%b want=0", i, dz);
      end
      checks++;
      if (hi_out !== eh[i] || lo_out !== el[i]) begin
        errors++;
        $display("FAIL div%0d_result got=%h_%h want=%h_%h",
                 i, hi_out, lo_out, eh[i], el[i]);
      end
    end
  endtask

  task automatic test_div_zero;
    int fd, nd;
    logic dz, b1;
    drive_op(1'b0, 32'd7, 32'hFFFFFFFD, -10, fd, nd, dz, b1);
    drive_op(1'b1, 32'd5, 32'd0, -10, fd, nd, dz, b1);
    checks++;
    if (fd != 1 || nd != 1) begin
      errors++;
      $display("FAIL divzero_done cyc=%0d n=%0d want cyc=1 n=1", fd, nd);
    end
    checks++;
    if (dz !== 1'b1) begin
      errors++;
      $display("FAIL divzero_flag got=%b want=1", dz);
    end
    checks++;
    if (hi_out !== 32'hFFFFFFFF || lo_out !== 32'hFFFFFFEB) begin
      errors++;
      $display("FAIL divzero_hold got=%h_%h want=ffffffff_ffffffeb",
               hi_out, lo_out);
    end
  endtask

  task automatic test_back_to_back;
    int fd, nd;
    logic dz, b1;
    drive_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 5, fd, nd, dz, b1);
    checks++;
    if (fd != 34 || nd != 1) begin
      errors++;
      $display("FAIL ovf_done cyc=%0d n=%0d want cyc=34 n=1", fd, nd);
    end
    checks++;
    if (dz !== 1'b0) begin
      errors++;
      $display("FAIL ovf_dz got=%b want=0", dz);
    end
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h80000000) begin
      errors++;
      $display("FAIL ovf_result got=%h_%h want=00000000_80000000",
               hi_out, lo_out);
    end
  endtask

  task automatic test_reset_mid;
    int nd;
    nd = 0;
    start = 1'b1;
    op    = 1'b0;
    src_a = 32'd7;
    src_b = 32'd3;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clock);
      #1;
      if (cyc == 1) start = 1'b0;
      if (cyc == 10) reset = 1'b1;
      if (cyc == 11) begin
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
          errors++;
          $display("FAIL abort_busy got=%b want=0", busy);
        end
        checks++;
        if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
          errors++;
          $display("FAIL abort_hilo got=%h_%h want=0", hi_out, lo_out);
        end
      end
      if (cyc >= 11 && done) nd++;
    end
    checks++;
    if (nd != 0) begin
      errors++;
      $display("FAIL abort_nodone got=%0d want=0", nd);
    end
  endtask

  task automatic test_reset_priority;
    reset = 1'b1;
    start = 1'b1;
    op    = 1'b0;
    src_a = 32'd3;
    src_b = 32'd4;
    @(posedge clock);
    #1;
    reset = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio_busy got=%b want=0", busy);
    end
    @(posedge clock);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_prio_idle got=%b%b want=00", busy, done);
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_div_zero();
    test_back_to_back();
    test_reset_mid();
    test_reset_priority();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
